// File: rtl/mips_pkg.sv
// Shared constants for the instruction fetch slice: widths, MIPS opcodes and the
// fetch FSM state encoding.
package mips_pkg;

  localparam int XLEN   = 32;
  localparam int OP_W   = 6;
  localparam int FUNC_W = 6;
  localparam int IMM_W  = 16;
  localparam int TGT_W  = 26;

  localparam logic [OP_W-1:0] OP_J   = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL = 6'b000011;
  localparam logic [OP_W-1:0] OP_BEQ = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE = 6'b000101;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2,
    FAULT = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC selection: jr > j/jal > taken branch > fall-through.
// FETCH_ALIGN_CHECK_EN: report misaligned targets instead of masking bits [1:0].
module next_pc_sel
  import mips_pkg::*;
(
  input  logic [XLEN-1:0]  pc_plus4,
  input  logic [TGT_W-1:0] target,
  input  logic             branch,
  input  logic             branchNot,
  input  logic             jump,
  input  logic             jumpReg,
  input  logic             jumpAndLink,
  input  logic             alu_zero,
  input  logic [XLEN-1:0]  rs_data,
  output logic [XLEN-1:0]  next_pc,
  output logic             misaligned
);

  logic            take_branch;
  logic [XLEN-1:0] br_off;
  logic [XLEN-1:0] raw_pc;

  always_comb begin
    take_branch = (branch & alu_zero) | (branchNot & ~alu_zero);
    // The branch immediate is the low half of the jump target field.
    br_off = {{(XLEN-IMM_W-2){target[IMM_W-1]}}, target[IMM_W-1:0], 2'b00};
    if (jumpReg) begin
      raw_pc = rs_data;
    end else if (jump | jumpAndLink) begin
      raw_pc = {pc_plus4[XLEN-1:XLEN-4], target, 2'b00};
    end else if (take_branch) begin
      raw_pc = pc_plus4 + br_off;
    end else begin
      raw_pc = pc_plus4;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  assign next_pc    = raw_pc;
  assign misaligned = |raw_pc[1:0];
`else
  assign next_pc    = raw_pc & ~32'h3;
  assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: FETCH -> WAIT -> ISSUE loop with a bounded ack wait and a
// sticky fault. Optional FETCH_ALIGN_CHECK_EN faults on misaligned next_pc.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          WAIT_LIMIT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [XLEN-1:0]    imem_rdata,
  output logic [XLEN-1:0]    instr,
  output logic [OP_W-1:0]    opcode,
  output logic [FUNC_W-1:0]  func,
  output logic               instr_valid,
  output logic [XLEN-1:0]    pc_plus4,
  input  logic               instr_ready,
  input  logic               branch,
  input  logic               branchNot,
  input  logic               jump,
  input  logic               jumpReg,
  input  logic               jumpAndLink,
  input  logic               alu_zero,
  input  logic [XLEN-1:0]    rs_data,
  output logic               fetch_fault,
  output fetch_state_e       state_dbg
);

  // imem handshake: imem_req is a one-cycle pulse in FETCH; the memory answers with
  // a one-cycle imem_ack (data on imem_rdata) while we sit in WAIT. Downstream,
  // instr_valid/instr_ready form a valid/ready pair: the held instruction retires on
  // the edge where both are high, and nothing changes while ready is low.
  localparam int CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_LIMIT - 1);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            instr_valid_q, instr_valid_d;
  logic            fault_q, fault_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic [XLEN-1:0] next_pc;
  logic            next_pc_misaligned;

  next_pc_sel u_next_pc_sel (
    .pc_plus4    (pc_plus4),
    .target      (instr_q[TGT_W-1:0]),
    .branch      (branch),
    .branchNot   (branchNot),
    .jump        (jump),
    .jumpReg     (jumpReg),
    .jumpAndLink (jumpAndLink),
    .alu_zero    (alu_zero),
    .rs_data     (rs_data),
    .next_pc     (next_pc),
    .misaligned  (next_pc_misaligned)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    fault_d       = fault_q;
    wait_cnt_d    = wait_cnt_q;
    case (state_q)
      FETCH: begin
        state_d    = WAIT;
        wait_cnt_d = '0;
      end
      WAIT: begin
        if (imem_ack) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          state_d       = ISSUE;
        end else if (wait_cnt_q == CNT_MAX) begin
          state_d = FAULT;
          fault_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ISSUE: begin
        if (instr_ready) begin
          instr_valid_d = 1'b0;
          if (next_pc_misaligned) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end else begin
            pc_d    = next_pc;
            state_d = FETCH;
          end
        end
      end
      default: begin
        instr_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      fault_q       <= fault_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  // Gate with rst_n so the request stays low while reset holds the FSM in FETCH.
  assign imem_req    = (state_q == FETCH) & rst_n;
  assign imem_addr   = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign func        = instr_q[5:0];
  assign instr_valid = instr_valid_q;
  assign fetch_fault = fault_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table of fetch/retire cases plus hand-written
// sequences for reset, hold, ack timeout, late ack and alignment.
module tb_fetch_unit;
  import mips_pkg::*;

  localparam int WLIM = 16;

  localparam logic [5:0] C_JR  = 6'b100000;
  localparam logic [5:0] C_J   = 6'b010000;
  localparam logic [5:0] C_JAL = 6'b001000;
  localparam logic [5:0] C_BR  = 6'b000100;
  localparam logic [5:0] C_BN  = 6'b000010;
  localparam logic [5:0] C_Z   = 6'b000001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic imem_req, imem_ack, instr_valid, instr_ready, fetch_fault;
  logic [31:0] imem_addr, imem_rdata, instr, pc_plus4, rs_data;
  logic [5:0] opcode, func;
  logic branch, branchNot, jump, jumpReg, jumpAndLink, alu_zero;
  fetch_state_e state_dbg;

  int n_vec = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    logic [5:0]  ctrl;
    logic [31:0] rs;
    int          delay;
    logic [31:0] exp_next;
  } vec_t;

  vec_t vecs[13];

  fetch_unit #(.RESET_PC(32'h0), .WAIT_LIMIT(WLIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .opcode(opcode), .func(func), .instr_valid(instr_valid), .pc_plus4(pc_plus4),
    .instr_ready(instr_ready),
    .branch(branch), .branchNot(branchNot), .jump(jump), .jumpReg(jumpReg),
    .jumpAndLink(jumpAndLink), .alu_zero(alu_zero), .rs_data(rs_data),
    .fetch_fault(fetch_fault), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0; rs_data = 32'h0;
    {jumpReg, jump, jumpAndLink, branch, branchNot, alu_zero} = 6'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_req", imem_req, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", instr_valid, 32'd0);
    check("rst_fault", fetch_fault, 32'd0);
    check("rst_instr", instr, 32'h0);
    rst_n = 1'b1;
    #1;
    check("rel_req", imem_req, 32'd1);
  endtask

  // Called while the DUT is in FETCH at addr; leaves it in ISSUE holding word.
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] word, input int delay);
    check("fetch_req", imem_req, 32'd1);
    check("fetch_addr", imem_addr, addr);
    tick();
    check("wait_req", imem_req, 32'd0);
    check("wait_valid", instr_valid, 32'd0);
    repeat (delay) tick();
    imem_ack = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    check("issue_valid", instr_valid, 32'd1);
    check("issue_instr", instr, word);
    check("issue_opcode", opcode, word[31:26]);
    check("issue_func", func, word[5:0]);
    check("issue_pc4", pc_plus4, addr + 32'd4);
    check("issue_state", 32'(state_dbg), 32'(ISSUE));
  endtask

  task automatic retire(input logic [5:0] ctrl, input logic [31:0] rs);
    {jumpReg, jump, jumpAndLink, branch, branchNot, alu_zero} = ctrl;
    rs_data = rs;
    instr_ready = 1'b1;
    tick();
    clear_inputs();
  endtask

  initial begin
    logic [31:0] cur_pc;
    vecs[0]  = '{32'h0000_0010, 32'h0000_0020, 6'b0,          32'h0,   0, 32'h0000_0014};
    vecs[1]  = '{32'h0000_0020, 32'h1000_FFFE, C_BR | C_Z,    32'h0,   1, 32'h0000_001C};
    vecs[2]  = '{32'h0000_0020, 32'h1000_FFFE, C_BN | C_Z,    32'h0,   0, 32'h0000_0024};
    vecs[3]  = '{32'h0000_0020, 32'h1000_FFFE, C_BR,          32'h0,   2, 32'h0000_0024};
    vecs[4]  = '{32'h0000_0020, 32'h1400_FFFE, C_BN,          32'h0,   0, 32'h0000_001C};
    vecs[5]  = '{32'h0000_0040, 32'h0800_0010, C_JR | C_J,    32'h400, 0, 32'h0000_0400};
    vecs[6]  = '{32'h0000_0030, 32'h0C00_0040, C_JAL,         32'h0,   3, 32'h0000_0100};
    vecs[7]  = '{32'h9000_0010, 32'h0800_0004, C_J,           32'h0,   0, 32'h9000_0010};
    vecs[8]  = '{32'hFFFF_FFFC, 32'h0000_0020, 6'b0,          32'h0,   1, 32'h0000_0000};
    vecs[9]  = '{32'h0000_0100, 32'h1000_0003, C_BR | C_Z,    32'h0,   0, 32'h0000_0110};
    vecs[10] = '{32'h0000_0200, 32'h0800_0080, C_J|C_BR|C_Z,  32'h0,   0, 32'h0000_0200};
    vecs[11] = '{32'h0000_0300, 32'h0000_0020, C_BR | C_Z,    32'h0,   0, 32'h0000_0384};
    vecs[12] = '{32'h0000_0050, 32'h0000_0020, 6'b0,          32'h800, 0, 32'h0000_0054};

    do_reset();

    // First fetch after reset, then hold with ready low while ack/controls wiggle.
    do_fetch(32'h0, 32'h012A_4020, 0);
    check("first_opcode", opcode, 32'h0);
    check("first_func", func, 32'h20);
    imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF; jumpReg = 1'b1; rs_data = 32'h800;
    repeat (3) tick();
    clear_inputs();
    check("hold_instr", instr, 32'h012A_4020);
    check("hold_valid", instr_valid, 32'd1);
    check("hold_req", imem_req, 32'd0);
    check("hold_addr", imem_addr, 32'h0);
    retire(6'b0, 32'h0);
    check("after_hold_addr", imem_addr, 32'h4);
    check("after_hold_valid", instr_valid, 32'd0);
    cur_pc = 32'h4;

    for (int i = 0; i < 13; i++) begin
      do_fetch(cur_pc, 32'h0000_0020, 0);
      retire(C_JR, vecs[i].pc);
      do_fetch(vecs[i].pc, vecs[i].word, vecs[i].delay);
      retire(vecs[i].ctrl, vecs[i].rs);
      check($sformatf("vec%0d_next", i), imem_addr, vecs[i].exp_next);
      check($sformatf("vec%0d_req", i), imem_req, 32'd1);
      cur_pc = vecs[i].exp_next;
    end

    // Misaligned register jump.
    do_fetch(cur_pc, 32'h0000_0020, 1);
    retire(C_JR, 32'h402);
`ifdef FETCH_ALIGN_CHECK_EN
    check("align_fault", fetch_fault, 32'd1);
    check("align_pc_kept", imem_addr, cur_pc);
    check("align_valid", instr_valid, 32'd0);
    check("align_req", imem_req, 32'd0);
`else
    check("align_mask_addr", imem_addr, 32'h400);
    check("align_no_fault", fetch_fault, 32'd0);
`endif

    // Reset in the middle of WAIT, then a late ack during the new FETCH.
    do_reset();
    tick();
    check("midwait_state", 32'(state_dbg), 32'(WAIT));
    rst_n = 1'b0;
    #1;
    check("midwait_async_state", 32'(state_dbg), 32'(FETCH));
    check("midwait_async_req", imem_req, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    check("late_ack_req", imem_req, 32'd1);
    tick();
    clear_inputs();
    check("late_ack_valid", instr_valid, 32'd0);
    check("late_ack_instr", instr, 32'h0);
    check("late_ack_state", 32'(state_dbg), 32'(WAIT));
    imem_ack = 1'b1; imem_rdata = 32'h0000_0020;
    tick();
    clear_inputs();
    check("post_late_instr", instr, 32'h0000_0020);
    check("post_late_valid", instr_valid, 32'd1);

    // Ack timeout: WLIM cycles of WAIT without ack.
    retire(6'b0, 32'h0);
    check("to_fetch_addr", imem_addr, 32'h4);
    tick();
    repeat (WLIM - 1) tick();
    check("to_not_yet", fetch_fault, 32'd0);
    check("to_still_wait", 32'(state_dbg), 32'(WAIT));
    tick();
    check("to_fault", fetch_fault, 32'd1);
    check("to_state", 32'(state_dbg), 32'(FAULT));
    check("to_req", imem_req, 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678; instr_ready = 1'b1; jumpReg = 1'b1;
    repeat (3) tick();
    clear_inputs();
    check("fault_valid", instr_valid, 32'd0);
    check("fault_req", imem_req, 32'd0);
    check("fault_sticky", fetch_fault, 32'd1);
    check("fault_addr", imem_addr, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, address of the first fetched instruction.
REQ-002 SHALL have parameter WAIT_LIMIT, default 16, maximum cycles to wait for imem_ack before faulting.
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have ports imem_req (output, 1), imem_addr (output, 32), imem_ack (input, 1) and imem_rdata (input, 32): instruction-memory request/acknowledge interface.
REQ-006 SHALL have ports instr (output, 32), opcode (output, 6), func (output, 6), instr_valid (output, 1) and pc_plus4 (output, 32): the held instruction and its fields, fed to the control unit.
REQ-007 SHALL have input port instr_ready (1): the datapath retires the held instruction this cycle.
REQ-008 SHALL have input ports branch, branchNot, jump, jumpReg and jumpAndLink (1 each) from the control unit, alu_zero (1) and rs_data (32).
REQ-009 SHALL have output port fetch_fault (1): sticky fault flag.

Function
REQ-010 FSM states: FETCH, WAIT, ISSUE, FAULT.
REQ-011 FETCH: imem_req=1 and imem_addr=pc for exactly one cycle; then go to WAIT.
REQ-012 WAIT: imem_req=0. On imem_ack=1: capture imem_rdata into instr, set instr_valid=1, go to ISSUE.
REQ-013 WAIT: the wait counter increments each cycle without ack. When it reaches WAIT_LIMIT-1 with no ack: go to FAULT, set fetch_fault=1.
REQ-014 ISSUE: instr, opcode=instr[31:26] and func=instr[5:0] are stable; imem_req=0.
REQ-015 ISSUE with instr_ready=1: pc loads next_pc, instr_valid drops next cycle, go to FETCH. With instr_ready=0: hold all state indefinitely.
REQ-016 next_pc priority:
- jumpReg: rs_data.
- jump or jumpAndLink: {pc_plus4[31:28], instr[25:0], 2'b00}.
- (branch & alu_zero) | (branchNot & ~alu_zero): pc_plus4 + (sign-extended instr[15:0] << 2).
- otherwise: pc_plus4.
REQ-017 pc_plus4 = pc + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
REQ-018 Control inputs are sampled only in ISSUE with instr_ready=1; they are ignored in every other state.
REQ-019 imem_ack arriving in FETCH, ISSUE or FAULT SHALL be ignored.
REQ-020 FAULT: instr_valid=0, imem_req=0, terminal until reset.
REQ-021 Minimum fetch-to-issue latency is 2 cycles (FETCH then WAIT with ack), plus 1 cycle per ack delay.

Reset
REQ-022 On rst_n=0, asynchronously: pc=RESET_PC, state=FETCH, instr=0, instr_valid=0, imem_req=0, fetch_fault=0, wait counter=0.
REQ-023 Reset asserted mid-WAIT abandons the request; a late ack after release SHALL be ignored until the next FETCH.
REQ-024 First imem_req SHALL assert in the first clock cycle after rst_n rises.

Configuration
REQ-025 Macro FETCH_ALIGN_CHECK_EN.
- Defined: a next_pc with bits [1:0] != 0 sends the FSM to FAULT with fetch_fault=1, and pc is not updated.
- Undefined: next_pc[1:0] is forced to 2'b00 and no alignment fault is raised.

Structure
REQ-026 Package mips_pkg SHALL hold the opcode constants (J=6'b000010, JAL=6'b000011, BEQ=6'b000100, BNE=6'b000101), the FSM state enum and the width constants.
REQ-027 Next-PC selection SHALL live in a combinational sub-module next_pc_sel; the FSM and registers SHALL stay in fetch_unit.

Verification
REQ-028 Reset release; ack 1 cycle after req with rdata=32'h012A4020 -> imem_addr=0; instr_valid=1 with opcode=0, func=6'b100000.
REQ-029 Fall-through: pc=0x10 issues, instr_ready=1 with all control inputs 0 -> next imem_addr=0x14.
REQ-030 Branch: pc=0x20, instr=32'h1000FFFE, branch=1, alu_zero=1 -> next imem_addr=0x1C; same instruction with branchNot=1, alu_zero=1 -> 0x24.
REQ-031 Jump priority: jumpReg=1 and jump=1 together, rs_data=0x400 -> next imem_addr=0x400. jal at pc=0x30 with target 26'h40 -> next imem_addr=0x100.
REQ-032 No ack for WAIT_LIMIT cycles -> fetch_fault=1, imem_req stays 0; an ack afterwards leaves instr_valid=0.
REQ-033 With FETCH_ALIGN_CHECK_EN defined, jumpReg with rs_data=0x402 -> fetch_fault=1 and pc unchanged. With the macro undefined -> next imem_addr=0x400.
